// File: rtl/fphub_accumulator.sv
// FPHUB packet accumulator: sums the operands of each packet through an external
// combinational FPHUB adder and presents the sum together with the operand count.
module fphub_accumulator #(
  parameter int unsigned M     = 23,
  parameter int unsigned E     = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [E+M:0]       in_data,
  input  logic               in_last,
  output logic [E+M:0]       add_x,
  output logic [E+M:0]       add_y,
  input  logic [E+M:0]       add_z,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [E+M:0]       out_data,
  output logic [CNT_W-1:0]   out_count
);

  localparam int unsigned W = E + M + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_ADD  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     opnd_q, opnd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             last_q, last_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             xfer;

  // Handshakes, packet sequencing and next values of the datapath registers.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    opnd_d      = opnd_q;
    count_d     = count_q;
    last_d      = last_q;
    xfer        = in_valid && in_ready_q;

    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          // First operand goes straight into the accumulator, no add needed.
          acc_d   = in_data;
          count_d = CNT_W'(1);
          last_d  = in_last;
          state_d = in_last ? S_OUT : S_ACC;
        end
      end
      S_ACC: begin
        if (xfer) begin
          opnd_d  = in_data;
          last_d  = in_last;
          if (count_q != CNT_MAX) begin
            count_d = count_q + CNT_W'(1);
          end
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        acc_d   = add_z;
        state_d = last_q ? S_OUT : S_ACC;
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d  = (state_d == S_IDLE) || (state_d == S_ACC);
    out_valid_d = (state_d == S_OUT);
  end

  // State and datapath registers; reset discards any partial packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      opnd_q      <= '0;
      count_q     <= '0;
      last_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      opnd_q      <= opnd_d;
      count_q     <= count_d;
      last_q      <= last_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = acc_q;
  assign out_count = count_q;
  assign add_x     = acc_q;
  assign add_y     = opnd_q;

endmodule

// File: tb/tb_fphub_accumulator.sv
// Bench for fphub_accumulator: two instances (CNT_W=16 and CNT_W=2) share the
// input stimulus; results are checked against a fold-over-operands model.
module tb_fphub_accumulator;

  localparam int unsigned M = 23;
  localparam int unsigned E = 8;
  localparam int unsigned W = E + M + 1;

  typedef logic [W-1:0] word_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_last;
  logic         out_ready;
  word_t        in_data;

  logic         in_ready, out_valid;
  word_t        add_x, add_y, add_z, out_data;
  logic [15:0]  out_count;

  logic         in_ready_s, out_valid_s;
  word_t        add_x_s, add_y_s, add_z_s, out_data_s;
  logic [1:0]   out_count_s;

  int n_cmp = 0;
  int n_err = 0;

  // Stand-in adder: real float results for the documented pairs, otherwise an
  // arbitrary mix (the block must pass whatever the adder returns).
  function automatic word_t add_f(input word_t x, input word_t y);
    if (x == 32'h3F80_0000 && y == 32'h4000_0000) return 32'h4040_0000;
    if (x == 32'h4040_0000 && y == 32'h4040_0000) return 32'h40C0_0000;
    return x + {y[15:0], y[31:16]} + 32'h0123_4567;
  endfunction

  assign add_z   = add_f(add_x, add_y);
  assign add_z_s = add_f(add_x_s, add_y_s);

  fphub_accumulator #(.M(M), .E(E), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .add_x(add_x), .add_y(add_y),
    .add_z(add_z), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count)
  );

  fphub_accumulator #(.M(M), .E(E), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .in_last(in_last), .add_x(add_x_s), .add_y(add_y_s),
    .add_z(add_z_s), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_data(out_data_s), .out_count(out_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Push one packet; checks the adder operands in every ADD cycle and the
  // result latency. Ends at the first negedge in which the sum should be valid.
  task automatic send_pkt(input word_t ops[$], input int gap_pct);
    word_t acc;
    int    t;
    acc = ops[0];
    for (int i = 0; i < ops.size(); i++) begin
      if (i > 0 && $urandom_range(99) < gap_pct) begin
        for (int g = 0; g < int'($urandom_range(3, 1)); g++) begin
          in_valid = 1'b0;
          in_data  = $urandom;
          in_last  = 1'($urandom);
          @(negedge clk);
        end
      end
      in_valid = 1'b1;
      in_data  = ops[i];
      in_last  = (i == ops.size() - 1);
      t = 0;
      while (!in_ready && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk("in_ready_wait", in_ready, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = $urandom;
      in_last  = 1'($urandom);
      if (i > 0) begin
        chk("add_x", add_x, acc);
        chk("add_y", add_y, ops[i]);
        chk("add_x_sat", add_x_s, acc);
        chk("rdy_in_add", in_ready, 1'b0);
        chk("vld_in_add", out_valid, 1'b0);
        acc = add_f(acc, ops[i]);
      end
    end
    if (ops.size() > 1) @(negedge clk);
    chk("latency_vld", out_valid, 1'b1);
  endtask

  // Drain one result with a given number of backpressure cycles.
  task automatic recv(input word_t exp_d, input int n, input int stall);
    logic [15:0] exp_c;
    logic [1:0]  exp_cs;
    exp_c  = 16'(n);
    exp_cs = (n >= 3) ? 2'd3 : 2'(n);
    for (int k = 0; k < stall; k++) begin
      out_ready = 1'b0;
      chk("stall_vld", out_valid, 1'b1);
      chk("stall_data", out_data, exp_d);
      chk("stall_count", out_count, exp_c);
      chk("stall_rdy", in_ready, 1'b0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk("out_vld", out_valid, 1'b1);
    chk("out_data", out_data, exp_d);
    chk("out_count", out_count, exp_c);
    chk("out_data_sat", out_data_s, exp_d);
    chk("out_count_sat", out_count_s, exp_cs);
    chk("out_vld_sat", out_valid_s, 1'b1);
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_vld", out_valid, 1'b0);
    chk("idle_rdy", in_ready, 1'b1);
  endtask

  task automatic run_pkt(input word_t ops[$], input int gap_pct, input int stall);
    word_t s;
    s = ops[0];
    for (int i = 1; i < ops.size(); i++) s = add_f(s, ops[i]);
    send_pkt(ops, gap_pct);
    recv(s, ops.size(), stall);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdy"}, in_ready, 1'b0);
    chk({tag, "_vld"}, out_valid, 1'b0);
    chk({tag, "_data"}, out_data, '0);
    chk({tag, "_count"}, out_count, '0);
    chk({tag, "_addx"}, add_x, '0);
    chk({tag, "_addy"}, add_y, '0);
    chk({tag, "_vld_sat"}, out_valid_s, 1'b0);
    chk({tag, "_count_sat"}, out_count_s, '0);
  endtask

  initial begin
    word_t ops[$];
    word_t ref_q[$];

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    #1;
    chk("rdy_after_deassert", in_ready, 1'b0);
    @(negedge clk);
    chk("rdy_first_edge", in_ready, 1'b1);

    // Single-operand packet.
    ops = {32'h3F80_0000};
    run_pkt(ops, 0, 0);

    // Three-operand packet through the float pairs.
    ops = {32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
    run_pkt(ops, 0, 0);

    // Five-cycle backpressure.
    ops = {32'h1111_0000, 32'h2222_0000};
    run_pkt(ops, 0, 5);

    // Five operands: saturates the narrow counter.
    ops = {};
    for (int i = 0; i < 5; i++) ops.push_back($urandom);
    run_pkt(ops, 0, 1);

    // Same operands with and without idle gaps give the same sum.
    ops = {};
    for (int i = 0; i < 4; i++) ops.push_back($urandom);
    run_pkt(ops, 0, 0);
    run_pkt(ops, 100, 0);

    // Reset while the second operand of a 2-operand packet is in ADD.
    in_valid = 1'b1;
    in_data  = 32'hAAAA_5555;
    in_last  = 1'b0;
    @(negedge clk);
    in_data  = 32'h5555_AAAA;
    in_last  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_reset_add", add_y, 32'h5555_AAAA);
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_add_reset");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("reset_hold_vld", out_valid, 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_vld", out_valid, 1'b0);
    ops = {32'h3F80_0000};
    run_pkt(ops, 0, 0);

    // Random packets.
    for (int p = 0; p < 30; p++) begin
      ops = {};
      for (int i = 0; i < int'($urandom_range(6, 1)); i++) ops.push_back($urandom);
      run_pkt(ops, ($urandom_range(1) == 1) ? 40 : 0, int'($urandom_range(3)));
    end

    ref_q = {};
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
